add_sub_seq: RTL and testbench

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

---
 rtl/add_sub_seq_if.sv | 24 ++
 rtl/add_sub_seq.sv | 129 ++++++++++++
 tb/tb_add_sub_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_seq_if.sv
// add_sub_seq_if: operand/result bundle for the chunk-serial adder.
// master drives the request, slave (the adder) drives status and result.
interface add_sub_seq_if #(
  parameter int width = 16
);
  logic             Start;
  logic             SubEn;
  logic [width-1:0] A;
  logic [width-1:0] B;
  logic             Busy;
  logic             Done;
  logic [width:0]   S;
  logic             Ovf;

  modport master (
    output Start, SubEn, A, B,
    input  Busy, Done, S, Ovf
  );

  modport slave (
    input  Start, SubEn, A, B,
    output Busy, Done, S, Ovf
  );
endinterface

// File: rtl/add_sub_seq.sv
// add_sub_seq: width-bit add/sub computed chunk bits per cycle.
// Overflow logic is built only when ADD_SUB_SEQ_OVF_EN is defined.
module add_sub_seq #(
  parameter int width = 16,
  parameter int chunk = 4
) (
  input logic          CLK,
  input logic          RST,
  add_sub_seq_if.slave bus
);
  localparam int N  = width / chunk;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic [width-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [width:0]   s_q, s_d;
  logic             done_q, done_d;

  int               base;
  logic [chunk-1:0] a_c;
  logic [chunk-1:0] b_c;
  logic [chunk-1:0] sum_c;
  logic             cout_c;
  logic             last_c;

  // operands are latched, so only the counter picks the active slice
  always_comb begin
    base = int'(cnt_q) * chunk;
    a_c  = a_q[base +: chunk];
    b_c  = b_q[base +: chunk];
    {cout_c, sum_c} = {1'b0, a_c}
                    + {1'b0, b_c}
                    + {{chunk{1'b0}}, carry_q};
    last_c = (state_q == RUN) && (cnt_q == LAST);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    s_d     = s_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          a_d     = bus.A;
          b_d     = bus.B ^ {width{bus.SubEn}};
          carry_d = bus.SubEn;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[base +: chunk] = sum_c;
        carry_d = cout_c;
        if (cnt_q == LAST) begin
          s_d     = {cout_c, acc_d};
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy = (state_q == RUN);
  assign bus.Done = done_q;
  assign bus.S    = s_q;

`ifdef ADD_SUB_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;

  // carry into the MSB recovered from the top bit of the last chunk
  always_comb begin
    msb_cin = sum_c[chunk-1] ^ a_c[chunk-1] ^ b_c[chunk-1];
    ovf_d   = ovf_q;
    if (last_c) ovf_d = msb_cin ^ cout_c;
  end

  always_ff @(posedge CLK) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.Ovf = ovf_q;
`else
  logic unused_last;
  assign unused_last = last_c;
  assign bus.Ovf     = 1'b0;
`endif
endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: scoreboard bench over chunk = 1, 4 and 16 instances
// sharing one stimulus stream.
module tb_add_sub_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub_en = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;

  logic [2:0]  done_w;
  logic [2:0]  busy_w;
  logic [2:0]  ovf_w;
  logic [16:0] s_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ref_op(input logic sub,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] bb;
    logic [16:0] s;
    logic        o;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
    o  = (a[15] == bb[15]) && (s[15] != a[15]);
`ifndef ADD_SUB_SEQ_OVF_EN
    o = 1'b0;
`endif
    return {o, s};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    localparam int N  = 16 / CH;

    add_sub_seq_if #(.width(16)) bus ();

    assign bus.Start = start;
    assign bus.SubEn = sub_en;
    assign bus.A     = op_a;
    assign bus.B     = op_b;

    add_sub_seq #(.width(16), .chunk(CH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
    );

    assign done_w[g] = bus.Done;
    assign busy_w[g] = bus.Busy;
    assign ovf_w[g]  = bus.Ovf;
    assign s_w[g]    = bus.S;

    logic [17:0] q [$];
    logic [17:0] item;
    int          mcnt    = 0;
    bit          mdone   = 1'b0;
    bit          armed   = 1'b0;
    logic [16:0] s_exp   = '0;
    logic        ovf_exp = 1'b0;

    always @(negedge clk) begin
      if (armed) begin
        check($sformatf("busy_c%0d", CH), 32'(bus.Busy), 32'(mcnt != 0));
        check($sformatf("done_c%0d", CH), 32'(bus.Done), 32'(mdone));
        if (mdone) begin
          if (q.size() == 0) begin
            check($sformatf("sb_empty_c%0d", CH), 32'(1), 32'(0));
          end else begin
            item    = q.pop_front();
            s_exp   = item[16:0];
            ovf_exp = item[17];
          end
        end
        check($sformatf("s_c%0d", CH), 32'(bus.S), 32'(s_exp));
        check($sformatf("ovf_c%0d", CH), 32'(bus.Ovf), 32'(ovf_exp));
      end
      mdone = 1'b0;
      if (rst) begin
        armed   = 1'b1;
        mcnt    = 0;
        s_exp   = '0;
        ovf_exp = 1'b0;
        q.delete();
      end else if (mcnt == 0) begin
        if (start) begin
          q.push_back(ref_op(sub_en, op_a, op_b));
          mcnt = N;
        end
      end else begin
        mcnt--;
        if (mcnt == 0) mdone = 1'b1;
      end
    end
  end

  task automatic run_op(input string tag, input logic sub,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] es, input logic eo);
    int lat;
    @(posedge clk); #1;
    start  = 1'b1;
    sub_en = sub;
    op_a   = a;
    op_b   = b;
    @(posedge clk); #1;
    start  = 1'b0;
    sub_en = 1'($urandom);
    op_a   = 16'($urandom);
    op_b   = 16'($urandom);
    lat = 0;
    while (!done_w[1] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_s"}, 32'(s_w[1]), 32'(es));
`ifdef ADD_SUB_SEQ_OVF_EN
    check({tag, "_ovf"}, 32'(ovf_w[1]), 32'(eo));
`else
    check({tag, "_ovf"}, 32'(ovf_w[1]), 32'(1'b0 & eo));
`endif
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done_w[1]), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_s", 32'(s_w[1]), 32'd0);
    check("rst_busy", 32'(busy_w[1]), 32'd0);
    check("rst_done", 32'(done_w[1]), 32'd0);
    check("rst_ovf", 32'(ovf_w[1]), 32'd0);

    run_op("add_basic", 1'b0, 16'h1234, 16'h0F0F, 17'h02143, 1'b0);
    run_op("sub_neg",   1'b1, 16'h0005, 16'h0007, 17'h0FFFE, 1'b0);
    run_op("sub_ovf",   1'b1, 16'h8000, 16'h0001, 17'h17FFF, 1'b1);
    run_op("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1);
    run_op("add_cout",  1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0);

    // Start held high with operands changing every cycle
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      start  = 1'b1;
      sub_en = 1'($urandom);
      op_a   = 16'($urandom);
      op_b   = 16'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);

    // reset two cycles after accept aborts the operation
    @(posedge clk); #1;
    start = 1'b1;
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("abort_nodone", 32'(done_w[1]), 32'd0);
      @(posedge clk); #1;
    end
    check("abort_s", 32'(s_w[1]), 32'd0);
    check("abort_busy", 32'(busy_w[1]), 32'd0);
    run_op("after_abort", 1'b0, 16'h0101, 16'h0202, 17'h00303, 1'b0);
    repeat (20) @(posedge clk);

    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      rst    = ($urandom_range(0, 999) == 0);
      start  = ($urandom_range(0, 3) != 0);
      sub_en = 1'($urandom);
      op_a   = 16'($urandom);
      op_b   = 16'($urandom);
    end
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    repeat (40) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
